// File: rtl/exp_req_arbiter.sv
// Round-robin front end that lets N_REQ lanes share one in-order exp unit.
// A tag FIFO records which lane issued each operand so its result can be routed back.
`timescale 1ns/1ps
module exp_req_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ*DATA_W-1:0]     req_x,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [DATA_W-1:0]           exp_x_in,
    output logic                        exp_x_in_valid,
    input  logic                        exp_x_in_ready,
    input  logic [DATA_W-1:0]           exp_out,
    input  logic                        exp_out_valid,
    output logic                        exp_out_ready,
    output logic [$clog2(MAX_OUTST):0]  outstanding,
    output logic                        proto_err
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(MAX_OUTST);

    logic                 active_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic                 lock_q;
    logic [IDX_W-1:0]     locked_idx_q;
    logic [IDX_W-1:0]     tag_mem_q [MAX_OUTST];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic [PTR_W:0]       count_d;
    logic                 proto_err_q;

    logic [IDX_W-1:0]     cand_idx;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic [IDX_W-1:0]     head;
    logic                 head_ready;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 issue_fire;
    logic                 push;
    logic                 pop;
    logic                 drain;

    // First requesting lane at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        logic [IDX_W:0] sum_v;
        logic           found_v;
        cand_idx = rr_ptr_q;
        found_v  = 1'b0;
        sum_v    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_v = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (sum_v >= (IDX_W+1)'(N_REQ)) begin
                sum_v = sum_v - (IDX_W+1)'(N_REQ);
            end
            if (!found_v && req_valid[sum_v[IDX_W-1:0]]) begin
                found_v  = 1'b1;
                cand_idx = sum_v[IDX_W-1:0];
            end
        end
    end

    assign grant      = lock_q ? locked_idx_q : cand_idx;
    assign rr_ptr_d   = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
    assign fifo_full  = (count_q == (PTR_W+1)'(MAX_OUTST));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    always_comb begin
        exp_x_in   = '0;
        head_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == IDX_W'(i)) begin
                exp_x_in = req_x[i*DATA_W +: DATA_W];
            end
            if (head == IDX_W'(i)) begin
                head_ready = rsp_ready[i];
            end
        end
    end

    // active_q keeps every handshake output low until the first clock after reset.
    assign exp_x_in_valid = active_q & (lock_q | (|req_valid)) & ~fifo_full;
    assign issue_fire     = exp_x_in_valid & exp_x_in_ready;
    assign exp_out_ready  = active_q & (fifo_empty | head_ready);
    assign push           = issue_fire;
    assign pop            = exp_out_valid & exp_out_ready & ~fifo_empty;
    assign drain          = exp_out_valid & exp_out_ready & fifo_empty;
    assign rsp_data       = exp_out;
    assign outstanding    = count_q;
    assign proto_err      = proto_err_q;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign req_ready[gi] = issue_fire & (grant == IDX_W'(gi));
            assign rsp_valid[gi] = active_q & exp_out_valid & ~fifo_empty & (head == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= 1'b0;
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            active_q <= 1'b1;
            count_q  <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Freeze the grant while the exp unit stalls so exp_x_in cannot change mid-offer.
            if (issue_fire) begin
                rr_ptr_q <= rr_ptr_d;
                lock_q   <= 1'b0;
            end else if (exp_x_in_valid) begin
                lock_q       <= 1'b1;
                locked_idx_q <= grant;
            end
            if (drain) begin
                proto_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_exp_req_arbiter.sv
// Bench for exp_req_arbiter: directed table, randomized run against a lane-level model, reset drain.
`timescale 1ns/1ps
module tb_exp_req_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*DW-1:0] req_x;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   rsp_data;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [DW-1:0]   exp_x_in;
    logic            exp_x_in_valid;
    logic            exp_x_in_ready;
    logic [DW-1:0]   exp_out;
    logic            exp_out_valid;
    logic            exp_out_ready;
    logic [2:0]      outstanding;
    logic            proto_err;

    always #5 clk = ~clk;

    exp_req_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_x(req_x), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .exp_x_in(exp_x_in), .exp_x_in_valid(exp_x_in_valid), .exp_x_in_ready(exp_x_in_ready),
        .exp_out(exp_out), .exp_out_valid(exp_out_valid), .exp_out_ready(exp_out_ready),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] lane_x(input int i);
        return 64'(i + 1) << 40;
    endfunction

    // Stand-in for the exp unit: any bijection works, the bench only checks routing.
    function automatic logic [63:0] f_exp(input logic [63:0] x);
        return {x[31:0], x[63:32]} ^ 64'h5A5A_0F0F_A5A5_F0F0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_x = '0;
        req_valid = 4'b1111;
        exp_out_valid = 1'b1;
        exp_out = '0;
        exp_x_in_ready = 1'b1;
        rsp_ready = 4'b1111;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_x_in_valid", 64'(exp_x_in_valid), 64'(0));
        chk("rst_out_ready", 64'(exp_out_ready), 64'(0));
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));
        @(posedge clk);
        #1;
        req_valid = '0;
        exp_out_valid = 1'b0;
        exp_x_in_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] v;
        logic       xr;
        logic       ov;
        logic [3:0] rr;
        logic [3:0] e_rdy;
        logic       e_xv;
        int         e_lane;
        logic [3:0] e_rsp;
        logic       e_eor;
        int         e_out;
    } vec_t;

    vec_t tbl[17];

    // Randomized-phase model state
    int           sb_lane[$];
    logic [63:0]  sb_x[$];
    logic [63:0]  st_x[$];
    int           st_t[$];
    bit           pend_v[N];
    logic [63:0]  pend_x[N];
    bit           offer_open;
    int           offer_lane;
    int           last_grant;
    int           cyc;

    task automatic rand_cycle();
        bit          exp_xv;
        logic [3:0]  e_rdy;
        logic [3:0]  e_rsp;
        logic        e_eor;
        bit          env_fire;
        bit          env_pop;
        bit          mdl_pop;
        logic [63:0] cap_x;
        logic [3:0]  cap_rdy;
        int          idx;
        int          t;
        for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
                pend_v[i] = 1'b1;
                pend_x[i] = {$urandom, $urandom};
            end
            req_valid[i] = pend_v[i];
            req_x[i*DW +: DW] = pend_x[i];
            rsp_ready[i] = ($urandom_range(0, 4) != 0);
        end
        exp_x_in_ready = ($urandom_range(0, 3) != 0) && (st_x.size() < 6);
        exp_out_valid = (st_x.size() > 0) && (st_t[0] <= cyc);
        exp_out = (st_x.size() > 0) ? f_exp(st_x[0]) : {$urandom, $urandom};
        @(negedge clk);
        exp_xv = (offer_open || (|req_valid)) && (sb_lane.size() < MO);
        if (!offer_open && exp_xv) begin
            offer_open = 1'b1;
            offer_lane = -1;
            for (int k = 0; k < N; k++) begin
                idx = (last_grant + 1 + k) % N;
                if (offer_lane < 0 && req_valid[idx]) offer_lane = idx;
            end
        end
        e_rdy = (exp_xv && exp_x_in_ready) ? (4'(1) << offer_lane) : 4'(0);
        chk("rnd_x_in_valid", 64'(exp_x_in_valid), 64'(exp_xv));
        chk("rnd_req_ready", 64'(req_ready), 64'(e_rdy));
        if (exp_xv) chk("rnd_x_in", exp_x_in, pend_x[offer_lane]);
        chk("rnd_outstanding", 64'(outstanding), 64'(sb_lane.size()));
        if (sb_lane.size() > 0) begin
            e_rsp = exp_out_valid ? (4'(1) << sb_lane[0]) : 4'(0);
            e_eor = rsp_ready[sb_lane[0]];
        end else begin
            e_rsp = '0;
            e_eor = 1'b1;
        end
        chk("rnd_rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        chk("rnd_out_ready", 64'(exp_out_ready), 64'(e_eor));
        chk("rnd_proto_err", 64'(proto_err), 64'(0));
        mdl_pop = (sb_lane.size() > 0) && exp_out_valid && e_eor;
        if (mdl_pop) chk("rnd_rsp_payload", rsp_data, f_exp(sb_x[0]));
        env_fire = exp_x_in_valid && exp_x_in_ready;
        env_pop = exp_out_valid && exp_out_ready;
        cap_x = exp_x_in;
        cap_rdy = req_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_xv && exp_x_in_ready) begin
            sb_lane.push_back(offer_lane);
            sb_x.push_back(pend_x[offer_lane]);
            last_grant = offer_lane;
            offer_open = 1'b0;
            $display("ISSUE lane=%0d x=%h outstanding=%0d", offer_lane, cap_x, sb_lane.size());
        end
        if (env_fire) begin
            t = cyc + int'($urandom_range(1, 4));
            if (st_t.size() > 0 && st_t[$] > t) t = st_t[$];
            st_x.push_back(cap_x);
            st_t.push_back(t);
        end
        for (int i = 0; i < N; i++) begin
            if (cap_rdy[i]) pend_v[i] = 1'b0;
        end
        if (mdl_pop) begin
            $display("RSP lane=%0d data=%h", sb_lane[0], f_exp(sb_x[0]));
            void'(sb_lane.pop_front());
            void'(sb_x.pop_front());
        end
        if (env_pop && st_x.size() > 0) begin
            void'(st_x.pop_front());
            void'(st_t.pop_front());
        end
    endtask

    initial begin
        //          v        xr    ov    rr       e_rdy    e_xv  lane  e_rsp    eor   out
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, -1, 4'b0000, 1'b1, 0};
        tbl[1]  = '{4'b0110, 1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1,  1, 4'b0000, 1'b1, 0};
        tbl[2]  = '{4'b0110, 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1,  2, 4'b0000, 1'b1, 1};
        tbl[3]  = '{4'b1001, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b1,  3, 4'b0000, 1'b1, 2};
        tbl[4]  = '{4'b1011, 1'b1, 1'b0, 4'b1111, 4'b1000, 1'b1,  3, 4'b0000, 1'b1, 2};
        tbl[5]  = '{4'b0011, 1'b1, 1'b1, 4'b1111, 4'b0001, 1'b1,  0, 4'b0010, 1'b1, 3};
        tbl[6]  = '{4'b0010, 1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1,  1, 4'b0000, 1'b1, 3};
        tbl[7]  = '{4'b0100, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, -1, 4'b0000, 1'b1, 4};
        tbl[8]  = '{4'b0100, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, -1, 4'b0100, 1'b1, 4};
        tbl[9]  = '{4'b0100, 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1,  2, 4'b0000, 1'b1, 3};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, -1, 4'b0000, 1'b1, 4};
        tbl[11] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, -1, 4'b1000, 1'b1, 4};
        tbl[12] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, -1, 4'b0001, 1'b1, 3};
        tbl[13] = '{4'b0000, 1'b1, 1'b1, 4'b1101, 4'b0000, 1'b0, -1, 4'b0010, 1'b0, 2};
        tbl[14] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, -1, 4'b0010, 1'b1, 2};
        tbl[15] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, -1, 4'b0100, 1'b1, 1};
        tbl[16] = '{4'b0000, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, -1, 4'b0000, 1'b1, 0};

        do_reset();
        for (int r = 0; r < 17; r++) begin
            for (int i = 0; i < N; i++) req_x[i*DW +: DW] = lane_x(i);
            req_valid = tbl[r].v;
            exp_x_in_ready = tbl[r].xr;
            exp_out_valid = tbl[r].ov;
            exp_out = 64'hA5A5_0000_0000_0000 | 64'(r);
            rsp_ready = tbl[r].rr;
            @(negedge clk);
            $display("ROW %0d valid=%b req_ready=%b rsp_valid=%b outstanding=%0d", r, req_valid, req_ready, rsp_valid, outstanding);
            chk($sformatf("row%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].e_rdy));
            chk($sformatf("row%0d_x_in_valid", r), 64'(exp_x_in_valid), 64'(tbl[r].e_xv));
            if (tbl[r].e_lane >= 0) chk($sformatf("row%0d_x_in", r), exp_x_in, lane_x(tbl[r].e_lane));
            chk($sformatf("row%0d_rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].e_rsp));
            chk($sformatf("row%0d_out_ready", r), 64'(exp_out_ready), 64'(tbl[r].e_eor));
            chk($sformatf("row%0d_outstanding", r), 64'(outstanding), 64'(tbl[r].e_out));
            chk($sformatf("row%0d_rsp_data", r), rsp_data, 64'hA5A5_0000_0000_0000 | 64'(r));
            chk($sformatf("row%0d_proto_err", r), 64'(proto_err), 64'(0));
            @(posedge clk);
            #1;
        end

        do_reset();
        offer_open = 1'b0;
        offer_lane = 0;
        last_grant = N - 1;
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_x[i] = '0;
        end
        for (int c = 0; c < 600; c++) rand_cycle();

        // Stale results after a mid-flight reset must be drained and flagged.
        do_reset();
        for (int i = 0; i < N; i++) req_x[i*DW +: DW] = lane_x(i);
        rsp_ready = 4'b1111;
        exp_x_in_ready = 1'b1;
        req_valid = 4'b0011;
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("drain_outstanding_before", 64'(outstanding), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("drain_async_outstanding", 64'(outstanding), 64'(0));
        chk("drain_async_out_ready", 64'(exp_out_ready), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            exp_out_valid = 1'b1;
            exp_out = f_exp(lane_x(p));
            @(negedge clk);
            $display("STALE pulse=%0d rsp_valid=%b out_ready=%b", p, rsp_valid, exp_out_ready);
            chk($sformatf("stale%0d_rsp_valid", p), 64'(rsp_valid), 64'(0));
            chk($sformatf("stale%0d_out_ready", p), 64'(exp_out_ready), 64'(1));
            chk($sformatf("stale%0d_outstanding", p), 64'(outstanding), 64'(0));
            @(posedge clk);
            #1;
            chk($sformatf("stale%0d_proto_err", p), 64'(proto_err), 64'(1));
        end
        exp_out_valid = 1'b0;
        @(negedge clk);
        chk("drain_outstanding_after", 64'(outstanding), 64'(0));
        chk("drain_proto_err_sticky", 64'(proto_err), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
